// File: rtl/lfsr_noise_gen.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_noise_gen
// Description : Multi-channel Galois-LFSR noise source with a valid/ready
//               output, white or binary mode and shift attenuation.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_noise_gen #(
    parameter int                DATA_W = 24,
    parameter int                LFSR_W = 32,
    parameter int                NUM_CH = 2,
    parameter logic [LFSR_W-1:0] TAPS   = 32'h80200003,
    parameter logic [LFSR_W-1:0] SEED   = 32'h00000001
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic                     i_seed_load,
    input  logic [LFSR_W-1:0]        i_seed,
    input  logic                     i_mode,
    input  logic [3:0]               i_shift,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [NUM_CH*DATA_W-1:0] o_data
);

    localparam logic [DATA_W-1:0] c_pos = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] c_neg = ~c_pos + DATA_W'(1);

    function automatic logic [LFSR_W-1:0] f_step(input logic [LFSR_W-1:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    function automatic logic [LFSR_W-1:0] f_rotl8(input logic [LFSR_W-1:0] s, input int k);
        logic [LFSR_W-1:0] r;
        r = s;
        for (int i = 0; i < 8 * k; i++) begin
            r = {r[LFSR_W-2:0], r[LFSR_W-1]};
        end
        return r;
    endfunction

    logic              r_valid;
    logic              w_load;
    logic              w_xfer;
    logic [LFSR_W-1:0] w_seed_base;

    // A zero seed would lock every channel at all-zero, so it falls back to SEED.
    assign w_seed_base = (i_seed == '0) ? SEED : i_seed;
    assign w_xfer      = r_valid & i_ready;
    assign w_load      = i_en & ~i_seed_load & (~r_valid | i_ready);
    assign o_valid     = r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
        end else if (i_seed_load) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam logic [LFSR_W-1:0] c_rst_seed = f_rotl8(SEED, k);

        logic [LFSR_W-1:0] r_lfsr;
        logic [DATA_W-1:0] r_sample;
        logic [LFSR_W-1:0] w_next;
        logic [DATA_W-1:0] w_raw;
        logic [DATA_W-1:0] w_pre;
        logic [DATA_W-1:0] w_out;

        assign w_next = f_step(r_lfsr);
        assign w_raw  = w_next[LFSR_W-1 -: DATA_W];
        assign w_pre  = i_mode ? (w_raw[DATA_W-1] ? c_neg : c_pos) : w_raw;
        assign w_out  = $signed(w_pre) >>> i_shift;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_lfsr   <= c_rst_seed;
                r_sample <= '0;
            end else if (i_seed_load) begin
                r_lfsr   <= f_rotl8(w_seed_base, k);
            end else if (w_load) begin
                r_lfsr   <= w_next;
                r_sample <= w_out;
            end
        end

        assign o_data[k*DATA_W +: DATA_W] = r_sample;
    end

endmodule
`default_nettype wire

// File: doc/lfsr_noise_gen.md
LFSR_NOISE_GEN -- requirements
Module: lfsr_noise_gen

Interface
REQ-001 The block SHALL have parameter DATA_W, default 24, giving the sample width per channel in bits (2..LFSR_W).
REQ-002 The block SHALL have parameter LFSR_W, default 32, giving the LFSR state width in bits.
REQ-003 The block SHALL have parameter NUM_CH, default 2, giving the number of independent noise channels (1..4).
REQ-004 The block SHALL have parameter TAPS, default 32'h80200003, giving the Galois feedback mask (x^32+x^22+x^2+x+1).
REQ-005 The block SHALL have parameter SEED, default 32'h00000001, giving the nonzero reset/substitute seed.
REQ-006 The block SHALL have port i_clk, input, 1 bit: single clock, with all state updating on its rising edge.
REQ-007 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port i_en, input, 1 bit: generation enable.
REQ-009 The block SHALL have port i_seed_load, input, 1 bit: one-cycle seed load strobe.
REQ-010 The block SHALL have port i_seed, input, LFSR_W bits: seed value for i_seed_load.
REQ-011 The block SHALL have port i_mode, input, 1 bit: 0 = white (multi-bit), 1 = binary (+/- full scale).
REQ-012 The block SHALL have port i_shift, input, 4 bits: arithmetic right-shift attenuation, 0..15.
REQ-013 The block SHALL have port i_ready, input, 1 bit: downstream accepts the sample.
REQ-014 The block SHALL have port o_valid, output, 1 bit: o_data holds an unconsumed sample.
REQ-015 The block SHALL have port o_data, output, NUM_CH*DATA_W bits: channel k occupies bits [k*DATA_W +: DATA_W], two's complement.

Function
REQ-016 Each channel SHALL hold one LFSR_W-bit Galois LFSR that steps as: lsb=1 -> (s>>1)^TAPS; lsb=0 -> s>>1.
REQ-017 The seed for channel k SHALL be its base seed rotated left by 8*k bits.
REQ-018 A transfer SHALL occur in any cycle with o_valid=1 and i_ready=1.
REQ-019 A load SHALL occur in any cycle with i_en=1, i_seed_load=0, and (o_valid=0 or i_ready=1).
REQ-020 On a load, every LFSR SHALL step once, and o_data SHALL register samples derived from the stepped states, with o_valid=1 on the next edge (1-cycle latency).
REQ-021 In any cycle with a transfer and no load, o_valid SHALL clear on the next edge.
REQ-022 Without a transfer, o_valid=1 SHALL persist and o_data SHALL stay stable, regardless of i_en, i_mode or i_shift.
REQ-023 The raw sample SHALL be the top DATA_W bits of the stepped state: s[LFSR_W-1 -: DATA_W].
REQ-024 In mode 1, the raw sample SHALL be replaced by +(2^(DATA_W-1)-1) when its MSB is 0, and by -(2^(DATA_W-1)-1) when its MSB is 1.
REQ-025 The output sample SHALL be the raw or binary value arithmetic-shifted right by i_shift, sign-extended, with no rounding.
REQ-026 The i_mode and i_shift values SHALL be sampled only in load cycles.
REQ-027 i_seed_load=1 SHALL have priority over a load: all LFSRs take the seeds derived from i_seed (REQ-017), o_valid clears, o_data is held, and no step occurs that cycle.
REQ-028 A seed value of zero SHALL be replaced by SEED so that no LFSR can enter the all-zero lock-up state.
REQ-029 With i_en=0, the LFSRs SHALL hold their state, while a pending sample remains available for transfer.
REQ-030 With TAPS maximal-length, each LFSR period SHALL be 2^LFSR_W-1 loads, wrapping back to its seed.

Reset
REQ-031 While i_rst_n=0, the block SHALL asynchronously set: LFSR k = rotl(SEED, 8k), o_valid=0, o_data=0.
REQ-032 Reset asserted mid-handshake SHALL discard any pending sample, and the first load after release SHALL produce the first-step values.

Verification
REQ-033 The bench SHALL check: defaults, reset release, i_en=1, i_ready=1, mode 0, shift 0 -> first valid ch0=0x802000, second ch0=0xC03000.
REQ-034 The bench SHALL check: i_ready=0 for 10 cycles after the first valid -> o_valid=1 and o_data constant at 0x802000; after i_ready=1, the next sample is 0xC03000.
REQ-035 The bench SHALL check: mode 1, shift 0 -> each channel is 0x7FFFFF or 0x800001 only; mode 1, shift 4 -> 0x07FFFF or 0xF80000.
REQ-036 The bench SHALL check: i_seed_load with i_seed=0 -> the sequence equals the post-reset sequence; i_seed_load with i_en=1 in the same cycle -> o_valid=0 and no step.
REQ-037 The bench SHALL check: LFSR_W=8, DATA_W=8, TAPS=8'hB8, NUM_CH=1 -> the sequence repeats after exactly 255 loads and never outputs 0x00.
REQ-038 The bench SHALL check: i_rst_n pulsed low while o_valid=1, i_ready=0 -> o_valid=0 and o_data=0 immediately, and the first post-reset sample is 0x802000.
